// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multicycle fetch/decode/execute sequencer for the 16-bit CPU.
// Ports: clk/resetn, run, mem_ready, instr in; datapath strobes, done/busy/illegal, state out.
module cpu_seq_ctrl #(
  parameter int NREG         = 8,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [15:0]     instr,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            pc_out,
  output logic            imm_out,
  output logic [NREG-1:0] r_out,
  output logic [NREG-1:0] r_in,
  output logic            a_load,
  output logic            g_load,
  output logic            g_out,
  output logic [1:0]      alu_op,
  output logic            done,
  output logic            busy,
  output logic            illegal,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    ALU0   = 3'd4,
    ALU1   = 3'd5,
    ALU2   = 3'd6,
    HALT   = 3'd7
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
  } ir_t;

  state_t cur, nxt;
  ir_t    ir;

  logic unused_bits;
  assign unused_bits = ^{instr[11], instr[7], instr[3:0]};

  // Out-of-range indices select nothing.
  function automatic logic [NREG-1:0] sel(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++)
      v[i] = (int'(idx) == i);
    return v;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur <= IDLE;
      ir  <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH && mem_ready) begin
        ir.op <= instr[15:12];
        ir.rx <= instr[10:8];
        ir.ry <= instr[6:4];
      end
    end
  end

  logic is_exec, is_alu;
  logic [1:0] aop;

  always_comb begin
    is_exec = 1'b0;
    is_alu  = 1'b0;
    aop     = 2'b00;
    unique case (1'b1)
      (ir.op == 4'd0),
      (ir.op == 4'd1),
      (ir.op == 4'd5),
      (ir.op == 4'd6): is_exec = 1'b1;
      (ir.op == 4'd2): is_alu  = 1'b1;
      (ir.op == 4'd3): begin
        is_alu = 1'b1;
        aop    = 2'b01;
      end
      (ir.op == 4'd4): begin
        is_alu = 1'b1;
        aop    = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt     = cur;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    pc_out  = 1'b0;
    imm_out = 1'b0;
    r_out   = '0;
    r_in    = '0;
    a_load  = 1'b0;
    g_load  = 1'b0;
    g_out   = 1'b0;
    alu_op  = 2'b00;
    done    = 1'b0;
    illegal = 1'b0;
    unique case (cur)
      IDLE: if (run) nxt = FETCH;
      FETCH: begin
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        if (is_exec) begin
          nxt = EXEC;
        end else if (is_alu) begin
          nxt = ALU0;
        end else begin
          illegal = 1'b1;
          if (ILLEGAL_HALT) begin
            nxt = HALT;
          end else begin
            done = 1'b1;
            nxt  = run ? FETCH : IDLE;
          end
        end
      end
      EXEC: begin
        done = 1'b1;
        nxt  = run ? FETCH : IDLE;
        unique case (ir.op)
          4'd0: begin
            imm_out = 1'b1;
            r_in    = sel(ir.rx);
          end
          4'd1: begin
            r_out = sel(ir.ry);
            r_in  = sel(ir.rx);
          end
          4'd5: begin
            pc_out = 1'b1;
            r_in   = sel(ir.rx);
          end
          4'd6: begin
            r_out   = sel(ir.rx);
            pc_load = 1'b1;
          end
          default: ;
        endcase
      end
      ALU0: begin
        r_out  = sel(ir.rx);
        a_load = 1'b1;
        nxt    = ALU1;
      end
      ALU1: begin
        r_out  = sel(ir.ry);
        g_load = 1'b1;
        alu_op = aop;
        nxt    = ALU2;
      end
      ALU2: begin
        g_out  = 1'b1;
        r_in   = sel(ir.rx);
        alu_op = aop;
        done   = 1'b1;
        nxt    = run ? FETCH : IDLE;
      end
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  assign busy  = (cur != IDLE) && (cur != HALT);
  assign state = cur;

  a_one_driver: assert property (
    @(posedge clk) disable iff (!resetn)
    $onehot0({pc_out, imm_out, g_out, r_out})
  );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: vector table + hand sequences on a halting instance,
// randomized run against a per-instruction schedule model on a non-halting instance.
module tb_cpu_seq_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_out;
    logic       imm_out;
    logic [7:0] r_out;
    logic [7:0] r_in;
    logic       a_load;
    logic       g_load;
    logic       g_out;
    logic [1:0] alu_op;
    logic       done;
    logic       busy;
    logic       illegal;
  } out_t;

  typedef struct {
    logic        rstn;
    logic        run;
    logic        rdy;
    logic [15:0] instr;
    out_t        exp;
  } vec_t;

  localparam int IRL = 1 << 0;
  localparam int PCI = 1 << 1;
  localparam int PCL = 1 << 2;
  localparam int PCO = 1 << 3;
  localparam int IMM = 1 << 4;
  localparam int AL  = 1 << 5;
  localparam int GL  = 1 << 6;
  localparam int GO  = 1 << 7;
  localparam int DN  = 1 << 8;
  localparam int BSY = 1 << 9;
  localparam int ILL = 1 << 10;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_HALT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0, run = 1'b0, rdy = 1'b0;
  logic [15:0] instr = '0;
  logic        rst0 = 1'b0, run0 = 1'b0, rdy0 = 1'b0;
  logic [15:0] instr0 = '0;

  logic       irl1, pci1, pcl1, pco1, imm1, al1, gl1, go1, dn1, bsy1, ill1;
  logic [7:0] ro1, ri1;
  logic [1:0] op1;
  logic [2:0] st1;
  logic       irl0, pci0, pcl0, pco0, imm0, al0, gl0, go0, dn0, bsy0, ill0;
  logic [7:0] ro0, ri0;
  logic [1:0] op0;
  logic [2:0] st0;

  cpu_seq_ctrl dut (
    .clk(clk), .resetn(rstn), .run(run), .mem_ready(rdy), .instr(instr),
    .ir_load(irl1), .pc_inc(pci1), .pc_load(pcl1), .pc_out(pco1),
    .imm_out(imm1), .r_out(ro1), .r_in(ri1), .a_load(al1), .g_load(gl1),
    .g_out(go1), .alu_op(op1), .done(dn1), .busy(bsy1), .illegal(ill1),
    .state(st1)
  );

  cpu_seq_ctrl #(.NREG(8), .ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .resetn(rst0), .run(run0), .mem_ready(rdy0), .instr(instr0),
    .ir_load(irl0), .pc_inc(pci0), .pc_load(pcl0), .pc_out(pco0),
    .imm_out(imm0), .r_out(ro0), .r_in(ri0), .a_load(al0), .g_load(gl0),
    .g_out(go0), .alu_op(op0), .done(dn0), .busy(bsy0), .illegal(ill0),
    .state(st0)
  );

  out_t got1, got0;
  assign got1 = {st1, irl1, pci1, pcl1, pco1, imm1, ro1, ri1,
                 al1, gl1, go1, op1, dn1, bsy1, ill1};
  assign got0 = {st0, irl0, pci0, pcl0, pco0, imm0, ro0, ri0,
                 al0, gl0, go0, op0, dn0, bsy0, ill0};

  int checks = 0;
  int errors = 0;

  function automatic out_t mk(input logic [2:0] st, input int f,
                              input logic [7:0] ro, input logic [7:0] ri,
                              input logic [1:0] op);
    out_t o;
    o = '0;
    o.st      = st;
    o.ir_load = (f & IRL) != 0;
    o.pc_inc  = (f & PCI) != 0;
    o.pc_load = (f & PCL) != 0;
    o.pc_out  = (f & PCO) != 0;
    o.imm_out = (f & IMM) != 0;
    o.a_load  = (f & AL) != 0;
    o.g_load  = (f & GL) != 0;
    o.g_out   = (f & GO) != 0;
    o.done    = (f & DN) != 0;
    o.busy    = (f & BSY) != 0;
    o.illegal = (f & ILL) != 0;
    o.r_out   = ro;
    o.r_in    = ri;
    o.alu_op  = op;
    return o;
  endfunction

  function automatic vec_t v(input logic rs, input logic rn, input logic rd,
                             input logic [15:0] in, input out_t e);
    vec_t x;
    x.rstn = rs; x.run = rn; x.rdy = rd; x.instr = in; x.exp = e;
    return x;
  endfunction

  task automatic chk(input string nm, input out_t g, input out_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s state=%0d got=%h exp=%h", nm, g.st, g, e);
    end
  endtask

  // Reference model: each fetched instruction becomes a list of
  // per-cycle expected outputs, from DECODE up to its last cycle.
  out_t q[$];
  int   mode = M_IDLE;

  function automatic logic [7:0] oh(input logic [2:0] i);
    return 8'(1) << i;
  endfunction

  task automatic build(input logic [15:0] w);
    logic [3:0] op;
    logic [2:0] rx, ry;
    logic [1:0] a;
    op = w[15:12]; rx = w[10:8]; ry = w[6:4];
    if (op >= 4'd7) begin
      q.push_back(mk(2, BSY | ILL | DN, 8'h0, 8'h0, 2'b0));
      return;
    end
    q.push_back(mk(2, BSY, 8'h0, 8'h0, 2'b0));
    case (op)
      4'd0: q.push_back(mk(3, IMM | DN | BSY, 8'h0, oh(rx), 2'b0));
      4'd1: q.push_back(mk(3, DN | BSY, oh(ry), oh(rx), 2'b0));
      4'd5: q.push_back(mk(3, PCO | DN | BSY, 8'h0, oh(rx), 2'b0));
      4'd6: q.push_back(mk(3, PCL | DN | BSY, oh(rx), 8'h0, 2'b0));
      default: begin
        a = 2'(op - 4'd2);
        q.push_back(mk(4, AL | BSY, oh(rx), 8'h0, 2'b0));
        q.push_back(mk(5, GL | BSY, oh(ry), 8'h0, a));
        q.push_back(mk(6, GO | DN | BSY, 8'h0, oh(rx), a));
      end
    endcase
  endtask

  function automatic out_t model_out();
    case (mode)
      M_FETCH: return mk(1, BSY | (rdy0 ? (IRL | PCI) : 0), 8'h0, 8'h0, 2'b0);
      M_EXEC:  return q[0];
      M_HALT:  return mk(7, 0, 8'h0, 8'h0, 2'b0);
      default: return mk(0, 0, 8'h0, 8'h0, 2'b0);
    endcase
  endfunction

  task automatic model_step();
    out_t e;
    case (mode)
      M_IDLE: if (run0) mode = M_FETCH;
      M_FETCH: begin
        if (rdy0) begin
          build(instr0);
          mode = M_EXEC;
        end
      end
      M_EXEC: begin
        e = q.pop_front();
        if (e.done) mode = run0 ? M_FETCH : M_IDLE;
        else if (q.size() == 0) mode = M_HALT;
      end
      default: ;
    endcase
  endtask

  vec_t tbl[$];
  out_t zi;

  initial begin
    zi = mk(0, 0, 8'h0, 8'h0, 2'b0);
    tbl.push_back(v(0, 0, 0, 16'h0000, zi));
    tbl.push_back(v(1, 1, 1, 16'h022A, zi));
    tbl.push_back(v(1, 1, 1, 16'h022A, mk(1, IRL | PCI | BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h2130, mk(2, BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h2130, mk(3, IMM | DN | BSY, 8'h0, 8'h04, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h2130, mk(1, IRL | PCI | BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h0000, mk(2, BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h0000, mk(4, AL | BSY, 8'h02, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h0000, mk(5, GL | BSY, 8'h08, 8'h0, 2'b00)));
    tbl.push_back(v(1, 1, 1, 16'h0000, mk(6, GO | DN | BSY, 8'h0, 8'h02, 2'b00)));
    tbl.push_back(v(1, 1, 0, 16'h4560, mk(1, BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 0, 16'h4560, mk(1, BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 0, 16'h4560, mk(1, BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h4560, mk(1, IRL | PCI | BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 0, 16'hF000, mk(2, BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 0, 16'hF000, mk(4, AL | BSY, 8'h20, 8'h0, 2'b0)));
    tbl.push_back(v(1, 0, 0, 16'hF000, mk(5, GL | BSY, 8'h40, 8'h0, 2'b10)));
    tbl.push_back(v(1, 0, 0, 16'hF000, mk(6, GO | DN | BSY, 8'h0, 8'h20, 2'b10)));
    tbl.push_back(v(1, 0, 1, 16'h0000, zi));
    tbl.push_back(v(1, 0, 1, 16'h0000, zi));
    tbl.push_back(v(1, 1, 1, 16'h9000, zi));
    tbl.push_back(v(1, 1, 1, 16'h9000, mk(1, IRL | PCI | BSY, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h0000, mk(2, BSY | ILL, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h0000, mk(7, 0, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(1, 1, 1, 16'h0000, mk(7, 0, 8'h0, 8'h0, 2'b0)));
    tbl.push_back(v(0, 1, 1, 16'h0000, zi));
    tbl.push_back(v(1, 0, 1, 16'h0000, zi));
    tbl.push_back(v(1, 0, 1, 16'h0000, zi));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rstn = tbl[i].rstn; run = tbl[i].run;
      rdy = tbl[i].rdy; instr = tbl[i].instr;
      #1;
      chk($sformatf("vec%0d", i), got1, tbl[i].exp);
    end

    // Reset asserted in the middle of an add.
    @(negedge clk); run = 1; rdy = 1; instr = 16'h2130;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("mid_alu1", got1, mk(5, GL | BSY, 8'h08, 8'h0, 2'b00));
    rstn = 0; #1;
    chk("mid_reset", got1, zi);
    @(negedge clk); rstn = 1; #1;
    chk("rel_idle", got1, zi);
    @(negedge clk); #1;
    chk("rel_fetch", got1, mk(1, IRL | PCI | BSY, 8'h0, 8'h0, 2'b0));

    // Non-halting instance: illegal is a one-cycle NOP.
    @(negedge clk); rst0 = 1; run0 = 1; rdy0 = 1; instr0 = 16'h9000; #1;
    chk("nh_idle", got0, zi);
    @(negedge clk); #1;
    chk("nh_fetch", got0, mk(1, IRL | PCI | BSY, 8'h0, 8'h0, 2'b0));
    @(negedge clk); #1;
    chk("nh_decode", got0, mk(2, BSY | ILL | DN, 8'h0, 8'h0, 2'b0));
    @(negedge clk); #1;
    chk("nh_refetch", got0, mk(1, IRL | PCI | BSY, 8'h0, 8'h0, 2'b0));
    @(negedge clk); rst0 = 0; #1;
    chk("nh_reset", got0, zi);
    mode = M_IDLE;
    q.delete();
    @(negedge clk); rst0 = 1; run0 = 0;

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      run0 = ($urandom % 8) != 0;
      rdy0 = ($urandom % 3) != 0;
      instr0[11:0] = 12'($urandom);
      if (($urandom % 4) != 0) instr0[15:12] = 4'($urandom % 7);
      else instr0[15:12] = 4'($urandom);
      #1;
      chk($sformatf("rnd%0d", n), got0, model_out());
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
